// File: rtl/flux_pkg.sv
// Shared definitions for the flux actor family: arbiter FSM states and
// default widths so neighbouring actors agree on token layout.
package flux_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } flux_state_e;

   localparam int FLUX_DEFAULT       = 2;
   localparam int DATA_WIDTH_DEFAULT = 18;
   localparam int SIZE_WIDTH_DEFAULT = 7;

endpackage

// File: rtl/read_interface.sv
// Bank of FLUX show-ahead FIFOs seen by a consumer: per-flux empty/read,
// with dout presenting the head of whichever FIFO is being read.
interface read_interface #(
   parameter int FLUX  = 2,
   parameter int WIDTH = 8
);
   logic [FLUX-1:0]  empty;
   logic [FLUX-1:0]  read;
   logic [WIDTH-1:0] dout;

   modport actor (input empty, input dout, output read);
   modport fifo  (output empty, output dout, input read);
endinterface

// File: rtl/write_interface.sv
// Single FIFO write port as seen by a producer.
interface write_interface #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             write;
   logic             full;

   modport actor (output din, output write, input full);
   modport fifo  (input din, input write, output full);
endinterface

// File: rtl/flux_rr_pick.sv
// Combinational round-robin pick: first requesting index above last,
// wrapping to the lowest requesting index at or below last.
module flux_rr_pick #(
   parameter int  FLUX      = 2,
   localparam int TAG_WIDTH = $clog2(FLUX)
) (
   input  logic [FLUX-1:0]      req,
   input  logic [TAG_WIDTH-1:0] last,
   output logic                 valid,
   output logic [TAG_WIDTH-1:0] idx
);

   // Wrapped candidates first, then candidates above last override them;
   // descending loops leave the lowest index in each group as the winner.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (req[i] && (i <= int'(last))) begin
            valid = 1'b1;
            idx   = TAG_WIDTH'(i);
         end
      end
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (req[i] && (i > int'(last))) begin
            valid = 1'b1;
            idx   = TAG_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/flux_burst_arbiter.sv
// Merges FLUX tagged data streams into one output, granting a whole burst
// (length taken from the per-flux size stream) to one flux at a time.
module flux_burst_arbiter
   import flux_pkg::*;
#(
   parameter int  FLUX       = FLUX_DEFAULT,
   parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int  SIZE_WIDTH = SIZE_WIDTH_DEFAULT,
   localparam int TAG_WIDTH  = $clog2(FLUX)
) (
   input  logic                 clk,
   input  logic                 rst,
   read_interface.actor         read_port_size,
   read_interface.actor         read_port_data,
   write_interface.actor        write_port,
   output logic [TAG_WIDTH-1:0] grant_tag,
   output logic                 busy
);

   flux_state_e           state_q, state_d;
   logic [SIZE_WIDTH-1:0] cnt_q, cnt_d;
   logic [SIZE_WIDTH-1:0] len_q, len_d;
   logic [TAG_WIDTH-1:0]  gnt_q, gnt_d;
   logic [TAG_WIDTH-1:0]  last_q, last_d;

   logic                  pick_valid;
   logic [TAG_WIDTH-1:0]  pick_idx;
   logic                  pick_now;
   logic                  xfer;
   logic                  last_beat;
   logic                  unused_tags;

   flux_rr_pick #(.FLUX(FLUX)) u_pick (
      .req   (~read_port_size.empty),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Everything visible is gated by rst so a reset cycle never consumes tokens.
   assign pick_now  = !rst && (state_q == IDLE) && pick_valid;
   assign xfer      = !rst && (state_q == BURST) && !read_port_data.empty[gnt_q]
                      && !write_port.full;
   assign last_beat = (cnt_q == (len_q - SIZE_WIDTH'(1)));

   assign busy      = !rst && (state_q == BURST);
   assign grant_tag = busy ? gnt_q : '0;

   // Kept separate from next-state logic: din and len depend on the FIFO
   // head that our own read selects, so mixing them would form a loop.
   assign write_port.din = {gnt_q, read_port_data.dout[DATA_WIDTH-1:0]};
   assign unused_tags    = ^{read_port_size.dout[SIZE_WIDTH+TAG_WIDTH-1:SIZE_WIDTH],
                             read_port_data.dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH]};

   always_comb begin
      read_port_size.read = '0;
      read_port_data.read = '0;
      write_port.write    = 1'b0;
      if (pick_now) begin
         read_port_size.read[pick_idx] = 1'b1;
      end
      if (xfer) begin
         read_port_data.read[gnt_q] = 1'b1;
         write_port.write           = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (pick_now) begin
               len_d = read_port_size.dout[SIZE_WIDTH-1:0];
               gnt_d = pick_idx;
               cnt_d = '0;
               // A zero-length burst is consumed in place and still rotates priority.
               if (len_d != '0) begin
                  state_d = BURST;
               end else begin
                  last_d = pick_idx;
               end
            end
         end
         BURST: begin
            if (xfer) begin
               if (last_beat) begin
                  state_d = IDLE;
                  last_d  = gnt_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + SIZE_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         gnt_q   <= '0;
         last_q  <= TAG_WIDTH'(FLUX - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_flux_burst_arbiter.sv
// Bench for flux_burst_arbiter: FIFO-bank environment, burst-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_flux_burst_arbiter;

   localparam int FLUX = 2;
   localparam int DW   = 18;
   localparam int SW   = 7;
   localparam int TW   = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          full;
   logic [TW-1:0] grant_tag;
   logic          busy;

   read_interface  #(.FLUX(FLUX), .WIDTH(SW + TW)) size_if ();
   read_interface  #(.FLUX(FLUX), .WIDTH(DW + TW)) data_if ();
   write_interface #(.WIDTH(DW + TW))              wr_if ();

   flux_burst_arbiter #(.FLUX(FLUX), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
      .clk            (clk),
      .rst            (rst),
      .read_port_size (size_if),
      .read_port_data (data_if),
      .write_port     (wr_if),
      .grant_tag      (grant_tag),
      .busy           (busy)
   );

   // FIFO contents of the environment
   logic [SW-1:0]    size_q [FLUX][$];
   logic [DW-1:0]    data_q [FLUX][$];
   logic [SW-1:0]    size_head [FLUX];
   logic [DW-1:0]    data_head [FLUX];
   logic [FLUX-1:0]  size_empty;
   logic [FLUX-1:0]  data_empty;
   logic [SW+TW-1:0] size_dout;
   logic [DW+TW-1:0] data_dout;
   logic [FLUX-1:0]  pop_s;
   logic [FLUX-1:0]  pop_d;

   logic [DW+TW-1:0] out_log [$];
   logic [DW+TW-1:0] exp_out [$];
   int               grant_log [$];
   int               exp_grant [$];

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;
   int stall_reads = 0;

   // Burst-level model: who owns the output and how many tokens remain.
   bit  m_busy  = 1'b0;
   int  m_owner = 0;
   int  m_rem   = 0;
   int  m_last  = FLUX - 1;

   logic [FLUX-1:0]  exp_sr, exp_dr;
   logic             exp_wr, exp_busy;
   int               exp_tag;
   logic [DW+TW-1:0] exp_din;
   int               pick;

   assign size_if.empty = size_empty;
   assign data_if.empty = data_empty;
   assign size_if.dout  = size_dout;
   assign data_if.dout  = data_dout;
   assign wr_if.full    = full;

   always_comb begin
      size_dout = '0;
      data_dout = '0;
      for (int i = 0; i < FLUX; i++) begin
         if (size_if.read[i]) size_dout = {TW'(i), size_head[i]};
         if (data_if.read[i]) data_dout = {TW'(i), data_head[i]};
      end
   end

   task automatic refresh();
      for (int i = 0; i < FLUX; i++) begin
         size_empty[i] = (size_q[i].size() == 0);
         data_empty[i] = (data_q[i].size() == 0);
         size_head[i]  = size_empty[i] ? '0 : size_q[i][0];
         data_head[i]  = data_empty[i] ? '0 : data_q[i][0];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_s(input int f, input int len);
      size_q[f].push_back(SW'(len));
      refresh();
   endtask

   task automatic push_d(input int f, input int payload);
      data_q[f].push_back(DW'(payload));
      refresh();
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic check_logs(input string tag);
      chk({tag, "_out_count"}, 32'(out_log.size()), 32'(exp_out.size()));
      for (int i = 0; i < out_log.size() && i < exp_out.size(); i++)
         chk($sformatf("%s_out%0d", tag, i), 32'(out_log[i]), 32'(exp_out[i]));
      chk({tag, "_grant_count"}, 32'(grant_log.size()), 32'(exp_grant.size()));
      for (int i = 0; i < grant_log.size() && i < exp_grant.size(); i++)
         chk($sformatf("%s_grant%0d", tag, i), 32'(grant_log[i]), 32'(exp_grant[i]));
      out_log.delete();
      exp_out.delete();
      grant_log.delete();
      exp_grant.delete();
      busy_cycles = 0;
      stall_reads = 0;
   endtask

   always @(negedge clk) begin
      exp_sr   = '0;
      exp_dr   = '0;
      exp_wr   = 1'b0;
      exp_busy = 1'b0;
      exp_tag  = 0;
      exp_din  = '0;
      pick     = -1;
      if (rst) begin
         m_busy  = 1'b0;
         m_last  = FLUX - 1;
         m_owner = 0;
         m_rem   = 0;
      end else if (!m_busy) begin
         for (int k = 1; k <= FLUX; k++)
            if (pick < 0 && size_q[(m_last + k) % FLUX].size() != 0) pick = (m_last + k) % FLUX;
         if (pick >= 0) begin
            exp_sr[pick] = 1'b1;
            if (size_q[pick][0] == '0) begin
               m_last = pick;
            end else begin
               m_busy  = 1'b1;
               m_owner = pick;
               m_rem   = int'(size_q[pick][0]);
            end
         end
      end else begin
         exp_busy = 1'b1;
         exp_tag  = m_owner;
         if (data_q[m_owner].size() != 0 && !full) begin
            exp_dr[m_owner] = 1'b1;
            exp_wr          = 1'b1;
            exp_din         = {TW'(m_owner), data_q[m_owner][0]};
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end
      end
      chk("size_read", 32'(size_if.read), 32'(exp_sr));
      chk("data_read", 32'(data_if.read), 32'(exp_dr));
      chk("write", 32'(wr_if.write), 32'(exp_wr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("grant_tag", 32'(grant_tag), 32'(exp_tag));
      if (exp_wr) chk("din", 32'(wr_if.din), 32'(exp_din));

      pop_s = size_if.read;
      pop_d = data_if.read;
      if (wr_if.write) out_log.push_back(wr_if.din);
      for (int i = 0; i < FLUX; i++)
         if (size_if.read[i]) grant_log.push_back(i);
      if (busy) busy_cycles++;
      if (full && (data_if.read != '0)) stall_reads++;
   end

   // FIFOs advance just after the edge so the DUT samples the old heads.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < FLUX; i++) begin
         if (pop_s[i] && size_q[i].size() != 0) void'(size_q[i].pop_front());
         if (pop_d[i] && data_q[i].size() != 0) void'(data_q[i].pop_front());
      end
      pop_s = '0;
      pop_d = '0;
      refresh();
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      bit found;
      rst   = 1'b1;
      full  = 1'b0;
      pop_s = '0;
      pop_d = '0;
      refresh();
      repeat (3) cyc();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_grant_tag", 32'(grant_tag), 32'd0);
      rst = 1'b0;
      check_logs("reset");

      // Two bursts back to back: flux0 len 3 then flux1 len 2
      push_s(0, 3);
      push_s(1, 2);
      for (int k = 0; k < 3; k++) push_d(0, 'h100 + k);
      for (int k = 0; k < 2; k++) push_d(1, 'h200 + k);
      repeat (10) cyc();
      chk("s1_busy_cycles", 32'(busy_cycles), 32'd5);
      exp_out = '{19'h00100, 19'h00101, 19'h00102, 19'h40200, 19'h40201};
      exp_grant = '{0, 1};
      check_logs("s1");

      // Unit bursts on both fluxes alternate
      for (int k = 0; k < 4; k++) begin
         push_s(0, 1);
         push_s(1, 1);
         push_d(0, 'h110 + k);
         push_d(1, 'h210 + k);
      end
      repeat (20) cyc();
      exp_out = '{19'h00110, 19'h40210, 19'h00111, 19'h40211,
                  19'h00112, 19'h40212, 19'h00113, 19'h40213};
      exp_grant = '{0, 1, 0, 1, 0, 1, 0, 1};
      check_logs("s2");

      // Output backpressure for two cycles after the second transfer
      push_s(0, 4);
      for (int k = 0; k < 4; k++) push_d(0, 'h300 + k);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cyc();
         if (out_log.size() == 2) found = 1'b1;
      end
      chk("s3_reached_two", 32'(found), 32'd1);
      stall_reads = 0;
      full = 1'b1;
      cyc();
      cyc();
      full = 1'b0;
      chk("s3_stall_reads", 32'(stall_reads), 32'd0);
      chk("s3_held_tokens", 32'(data_q[0].size()), 32'd2);
      repeat (8) cyc();
      exp_out = '{19'h00300, 19'h00301, 19'h00302, 19'h00303};
      exp_grant = '{0};
      check_logs("s3");

      // Zero-length burst on flux1, then flux0 must win the next pick
      push_s(1, 0);
      repeat (3) cyc();
      chk("s4_no_write", 32'(out_log.size()), 32'd0);
      chk("s4_size_consumed", 32'(size_q[1].size()), 32'd0);
      push_s(0, 1);
      push_s(1, 1);
      push_d(0, 'h400);
      push_d(1, 'h401);
      repeat (8) cyc();
      exp_out = '{19'h00400, 19'h40401};
      exp_grant = '{1, 0, 1};
      check_logs("s4");

      // Reset in the middle of a 5-token burst
      push_s(0, 5);
      for (int k = 0; k < 5; k++) push_d(0, 'h500 + k);
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         cyc();
         if (out_log.size() == 2) found = 1'b1;
      end
      chk("s5_reached_two", 32'(found), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("s5_left_tokens", 32'(data_q[0].size()), 32'd3);
      chk("s5_busy_after_rst", 32'(busy), 32'd0);
      push_s(0, 3);
      push_s(1, 1);
      push_d(1, 'h510);
      repeat (12) cyc();
      exp_out = '{19'h00500, 19'h00501, 19'h00502, 19'h00503, 19'h00504, 19'h40510};
      exp_grant = '{0, 0, 1};
      check_logs("s5");

      // Flux0 owns the output with no data; flux1 data must stay untouched
      push_s(0, 2);
      push_d(1, 'h600);
      push_d(1, 'h601);
      repeat (5) cyc();
      chk("s6_flux1_untouched", 32'(data_q[1].size()), 32'd2);
      chk("s6_busy_stalled", 32'(busy), 32'd1);
      chk("s6_grant_stalled", 32'(grant_tag), 32'd0);
      push_d(0, 'h610);
      push_d(0, 'h611);
      repeat (5) cyc();
      push_s(1, 2);
      repeat (6) cyc();
      exp_out = '{19'h00610, 19'h00611, 19'h40600, 19'h40601};
      exp_grant = '{0, 1};
      check_logs("s6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
